// File: rtl/div_frontend.sv
// div_frontend: request/response wrapper around an unsigned sequential divider.
// It converts signed operands to magnitudes and restores the result signs.
// It bypasses the divider for a zero divisor and abandons a divider that stalls.
module div_frontend #(
  parameter int BLANK_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 48
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_dividend,
  input  logic [31:0] req_divisor,
  input  logic        req_signed,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  input  logic        div_done,
  input  logic [31:0] div_quotient,
  input  logic [31:0] div_remainder,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_quotient,
  output logic [31:0] rsp_remainder,
  output logic        rsp_dbz,
  output logic        rsp_timeout
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] BLANK_LAST   = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_div_dividend;
  logic [31:0]   r_div_divisor;
  logic          r_q_neg;
  logic          r_r_neg;
  logic [31:0]   r_rsp_q;
  logic [31:0]   r_rsp_r;
  logic          r_dbz;
  logic          r_timeout;

  logic          w_accept;
  logic          w_div_zero;
  logic          w_dvd_neg;
  logic          w_dvs_neg;
  logic [31:0]   w_dvd_mag;
  logic [31:0]   w_dvs_mag;
  logic          w_timeout_hit;
  logic          w_issue_end;
  logic          w_capture;
  logic          w_abandon;
  logic [31:0]   w_corr_q;
  logic [31:0]   w_corr_r;

  // Operand conditioning: a negative signed operand is replaced by its magnitude.
  // The most negative value maps to 32'h80000000, which the unsigned divider handles.
  assign w_accept   = req_valid && (r_state == IDLE);
  assign w_div_zero = (req_divisor == 32'd0);
  assign w_dvd_neg  = req_signed && req_dividend[31];
  assign w_dvs_neg  = req_signed && req_divisor[31];
  assign w_dvd_mag  = w_dvd_neg ? (32'd0 - req_dividend) : req_dividend;
  assign w_dvs_mag  = w_dvs_neg ? (32'd0 - req_divisor)  : req_divisor;

  // The counter runs from 0 on entry to ISSUE.
  // The last blanking cycle and the last allowed cycle are both decoded from it.
  assign w_timeout_hit = (r_cnt == TIMEOUT_LAST);
  assign w_issue_end   = (r_cnt == BLANK_LAST);

  // A done seen in WAIT takes priority over a timeout on the same edge.
  assign w_capture = (r_state == WAIT) && div_done;
  assign w_abandon = ((r_state == ISSUE) || (r_state == WAIT)) && !w_capture && w_timeout_hit;

  // Result sign restoration from the flags latched at accept.
  assign w_corr_q = r_q_neg ? (32'd0 - div_quotient)  : div_quotient;
  assign w_corr_r = r_r_neg ? (32'd0 - div_remainder) : div_remainder;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic. ISSUE blanks div_done until the divider has seen the new operands.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next = w_div_zero ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        if (w_timeout_hit) begin
          w_next = RESP;
        end else if (w_issue_end) begin
          w_next = WAIT;
        end
      end
      WAIT: begin
        if (w_capture || w_timeout_hit) begin
          w_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Cycle counter: cleared on accept, advanced while the divider is busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
    end else if ((r_state == ISSUE) || (r_state == WAIT)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Divider operands and sign flags change only on a real (non-zero divisor) accept.
  // Holding them otherwise keeps the divider from restarting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_dividend <= 32'd0;
      r_div_divisor  <= 32'd0;
      r_q_neg        <= 1'b0;
      r_r_neg        <= 1'b0;
    end else if (w_accept && !w_div_zero) begin
      r_div_dividend <= w_dvd_mag;
      r_div_divisor  <= w_dvs_mag;
      r_q_neg        <= w_dvd_neg ^ w_dvs_neg;
      r_r_neg        <= w_dvd_neg;
    end
  end

  // Response registers are loaded from the bypass, the divider or the timeout.
  // They are held through RESP; the flags clear on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_q   <= 32'd0;
      r_rsp_r   <= 32'd0;
      r_dbz     <= 1'b0;
      r_timeout <= 1'b0;
    end else if (w_accept && w_div_zero) begin
      r_rsp_q   <= 32'hFFFF_FFFF;
      r_rsp_r   <= req_dividend;
      r_dbz     <= 1'b1;
      r_timeout <= 1'b0;
    end else if (w_capture) begin
      r_rsp_q   <= w_corr_q;
      r_rsp_r   <= w_corr_r;
      r_dbz     <= 1'b0;
      r_timeout <= 1'b0;
    end else if (w_abandon) begin
      r_rsp_q   <= 32'd0;
      r_rsp_r   <= 32'd0;
      r_dbz     <= 1'b0;
      r_timeout <= 1'b1;
    end else if ((r_state == RESP) && rsp_ready) begin
      r_dbz     <= 1'b0;
      r_timeout <= 1'b0;
    end
  end

  assign req_ready     = (r_state == IDLE);
  assign rsp_valid     = (r_state == RESP);
  assign div_dividend  = r_div_dividend;
  assign div_divisor   = r_div_divisor;
  assign rsp_quotient  = r_rsp_q;
  assign rsp_remainder = r_rsp_r;
  assign rsp_dbz       = r_dbz;
  assign rsp_timeout   = r_timeout;

endmodule

// File: tb/tb_div_frontend.sv
// tb_div_frontend: scoreboard bench for div_frontend.
// A model sequential divider and a behavioural arithmetic reference are used.
module tb_div_frontend;

  localparam int BLANK = 2;
  localparam int TMO   = 48;
  localparam int LAT   = 34;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_dividend = 32'd0;
  logic [31:0] req_divisor = 32'd0;
  logic        req_signed = 1'b0;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic        div_done;
  logic [31:0] div_quotient;
  logic [31:0] div_remainder;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_quotient;
  logic [31:0] rsp_remainder;
  logic        rsp_dbz;
  logic        rsp_timeout;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    logic        to;
  } exp_t;

  exp_t expQ[$];
  logic [31:0] lastA = 32'd0;
  logic [31:0] lastB = 32'd0;

  always #5 clk = ~clk;

  div_frontend #(.BLANK_CYCLES(BLANK), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor), .req_signed(req_signed),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_done(div_done), .div_quotient(div_quotient), .div_remainder(div_remainder),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
    .rsp_dbz(rsp_dbz), .rsp_timeout(rsp_timeout)
  );

  // Model divider: restarts when its operands change.
  // It raises done LAT cycles later and holds done while the operands stay put.
  logic        divStall = 1'b0;
  logic [31:0] mA = 32'd0;
  logic [31:0] mB = 32'd0;
  int          mCnt = 0;
  logic        mDone = 1'b0;

  always @(posedge clk) begin
    if (div_dividend !== mA || div_divisor !== mB) begin
      mA    <= div_dividend;
      mB    <= div_divisor;
      mCnt  <= LAT - 1;
      mDone <= 1'b0;
    end else if (mCnt > 0) begin
      mCnt <= mCnt - 1;
    end else begin
      mDone <= 1'b1;
    end
  end

  assign div_done      = mDone && !divStall;
  assign div_quotient  = (mB == 32'd0) ? 32'hFFFF_FFFF : mA / mB;
  assign div_remainder = (mB == 32'd0) ? mA : mA % mB;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  function automatic longint toLong(input logic [31:0] x, input logic sgn);
    int s;
    longint v;
    if (sgn) begin
      s = x;
      v = s;
    end else begin
      v = {32'd0, x};
    end
    return v;
  endfunction

  function automatic logic [31:0] magOf(input logic [31:0] x, input logic sgn);
    longint v;
    v = toLong(x, sgn);
    if (v < 0) v = -v;
    return v[31:0];
  endfunction

  // Reference: integer division truncating toward zero; the remainder takes the dividend's sign.
  function automatic exp_t refModel(input logic [31:0] dvd, input logic [31:0] dvs,
                                    input logic sgn, input logic stall);
    exp_t   e;
    longint a, b, q, r;
    e.dbz = 1'b0;
    e.to  = 1'b0;
    if (dvs == 32'd0) begin
      e.q   = 32'hFFFF_FFFF;
      e.r   = dvd;
      e.dbz = 1'b1;
    end else if (stall) begin
      e.q  = 32'd0;
      e.r  = 32'd0;
      e.to = 1'b1;
    end else begin
      a = toLong(dvd, sgn);
      b = toLong(dvs, sgn);
      q = a / b;
      r = a % b;
      e.q = q[31:0];
      e.r = r[31:0];
    end
    return e;
  endfunction

  // Monitor: pops an expectation at each response handshake.
  // While a response is held it also checks that the outputs do not move.
  logic        prevValid = 1'b0;
  logic [31:0] prevQ, prevR;
  logic        prevDbz, prevTo;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst_n) begin
      prevValid = 1'b0;
    end else if (rsp_valid) begin
      if (prevValid) begin
        checkOutput("hold_quotient", rsp_quotient, prevQ);
        checkOutput("hold_remainder", rsp_remainder, prevR);
        checkOutput("hold_dbz", rsp_dbz, prevDbz);
        checkOutput("hold_timeout", rsp_timeout, prevTo);
      end
      checkOutput("dbz_timeout_exclusive", rsp_dbz & rsp_timeout, 1'b0);
      if (rsp_ready) begin
        if (expQ.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_response: got q=%h r=%h, expected no response", rsp_quotient, rsp_remainder);
        end else begin
          e = expQ.pop_front();
          checkOutput("rsp_quotient", rsp_quotient, e.q);
          checkOutput("rsp_remainder", rsp_remainder, e.r);
          checkOutput("rsp_dbz", rsp_dbz, e.dbz);
          checkOutput("rsp_timeout", rsp_timeout, e.to);
        end
        prevValid = 1'b0;
      end else begin
        prevValid = 1'b1;
        prevQ     = rsp_quotient;
        prevR     = rsp_remainder;
        prevDbz   = rsp_dbz;
        prevTo    = rsp_timeout;
      end
    end else begin
      prevValid = 1'b0;
    end
  end

  task automatic checkResetState();
    checkOutput("reset_req_ready", req_ready, 1'b1);
    checkOutput("reset_rsp_valid", rsp_valid, 1'b0);
    checkOutput("reset_rsp_dbz", rsp_dbz, 1'b0);
    checkOutput("reset_rsp_timeout", rsp_timeout, 1'b0);
    checkOutput("reset_rsp_quotient", rsp_quotient, 32'd0);
    checkOutput("reset_rsp_remainder", rsp_remainder, 32'd0);
    checkOutput("reset_div_dividend", div_dividend, 32'd0);
    checkOutput("reset_div_divisor", div_divisor, 32'd0);
  endtask

  // One request from offer to handshake. It is entered and left just after a rising edge.
  // A non-zero abortAfter pulses reset that many cycles after accept instead of completing.
  task automatic applyStimulus(input logic [31:0] dvd, input logic [31:0] dvs, input logic sgn,
                               input logic stall, input int readyDelay, input int abortAfter);
    int guard;
    divStall     = stall;
    req_dividend = dvd;
    req_divisor  = dvs;
    req_signed   = sgn;
    req_valid    = 1'b1;
    guard = 0;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      guard++;
      if (guard > 200) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL accept_wait: got req_ready=0 for 200 cycles, expected 1");
        req_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    req_valid    = 1'b0;
    req_dividend = $urandom;
    req_divisor  = $urandom;
    req_signed   = 1'($urandom_range(0, 1));
    expQ.push_back(refModel(dvd, dvs, sgn, stall));
    if (dvs != 32'd0) begin
      lastA = magOf(dvd, sgn);
      lastB = magOf(dvs, sgn);
    end
    @(negedge clk);
    checkOutput("req_ready_after_accept", req_ready, 1'b0);
    checkOutput("div_dividend", div_dividend, lastA);
    checkOutput("div_divisor", div_divisor, lastB);
    if (dvs == 32'd0) checkOutput("dbz_latency", rsp_valid, 1'b1);

    if (abortAfter > 0) begin
      repeat (abortAfter) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checkResetState();
      expQ.delete();
      lastA    = 32'd0;
      lastB    = 32'd0;
      divStall = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      return;
    end

    guard = 0;
    while (!rsp_valid) begin
      @(negedge clk);
      guard++;
      if (guard > TMO + 10) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL response_wait: got rsp_valid=0 after %0d cycles, expected 1", guard);
        expQ.delete();
        @(posedge clk);
        #1;
        divStall = 1'b0;
        return;
      end
    end
    repeat (readyDelay + 1) @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    divStall  = 1'b0;
    @(negedge clk);
    checkOutput("idle_req_ready", req_ready, 1'b1);
    checkOutput("idle_rsp_valid", rsp_valid, 1'b0);
    checkOutput("idle_rsp_dbz", rsp_dbz, 1'b0);
    checkOutput("idle_rsp_timeout", rsp_timeout, 1'b0);
    @(posedge clk);
    #1;
  endtask

  initial begin : stimulus
    logic [31:0] a, b;
    logic        s, st;
    #12;
    checkResetState();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed cases.
    applyStimulus(32'd100, 32'd7, 1'b0, 1'b0, 0, 0);
    applyStimulus(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 2, 0);
    applyStimulus(32'h0000_1234, 32'd0, 1'b0, 1'b0, 1, 0);
    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 0, 0);
    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 0, 0);
    applyStimulus(32'd555, 32'd11, 1'b0, 1'b1, 5, 0);
    applyStimulus(32'hFFFF_FF00, 32'hFFFF_FFF0, 1'b0, 1'b0, 0, 0);
    applyStimulus(32'd12345, 32'hFFFF_FFFD, 1'b1, 1'b0, 3, 0);
    applyStimulus(32'd1000, 32'd3, 1'b0, 1'b0, 0, 10);
    applyStimulus(32'd1000, 32'd3, 1'b0, 1'b0, 0, 0);

    // Randomised traffic.
    for (int i = 0; i < 40; i++) begin
      a  = $urandom;
      s  = 1'($urandom_range(0, 1));
      st = ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF;
        3:       b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      applyStimulus(a, b, s, st, $urandom_range(0, 4), 0);
    end

    checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: got no completion by 500000 ns, expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule

// File: doc/div_frontend.md
DIV_FRONTEND -- requirements
Module: div_frontend

Interface
REQ-001 Parameter BLANK_CYCLES, default 2: cycles after operand issue during which div_done is ignored.
REQ-002 Parameter TIMEOUT_CYCLES, default 48: maximum cycles from issue to div_done before the operation is abandoned.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock, shared with the downstream sequential divider.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 req_valid  in  1  request offered.
REQ-007 req_ready  out  1  front end can accept a request.
REQ-008 req_dividend  in  32  dividend.
REQ-009 req_divisor  in  32  divisor.
REQ-010 req_signed  in  1  1 = two's-complement operands, 0 = unsigned.
REQ-011 div_dividend  out  32  registered unsigned dividend to the divider.
REQ-012 div_divisor  out  32  registered unsigned divisor to the divider.
REQ-013 div_done  in  1  divider done flag.
REQ-014 div_quotient  in  32  divider unsigned quotient.
REQ-015 div_remainder  in  32  divider unsigned remainder.
REQ-016 rsp_valid  out  1  result available.
REQ-017 rsp_ready  in  1  consumer accepts the result.
REQ-018 rsp_quotient  out  32  final quotient.
REQ-019 rsp_remainder  out  32  final remainder.
REQ-020 rsp_dbz  out  1  result came from a divide-by-zero bypass.
REQ-021 rsp_timeout  out  1  divider failed to finish within TIMEOUT_CYCLES.

Function
REQ-022 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT and RESP.
REQ-023 req_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge where req_valid=1 and req_ready=1.
REQ-024 On accept with divisor != 0, the block SHALL do all of the following at that edge and then enter ISSUE:
- load div_dividend and div_divisor with the operand magnitudes (two's-complement negation of negative operands when req_signed=1, else the raw values);
- latch the sign flags: quotient negative = signs differ, remainder negative = dividend negative.
REQ-025 On accept with divisor == 0, the block SHALL leave div_dividend and div_divisor unchanged and enter RESP on the next edge with rsp_dbz=1, rsp_quotient=32'hFFFFFFFF and rsp_remainder=req_dividend.
REQ-026 ISSUE SHALL last exactly BLANK_CYCLES cycles with div_done ignored, then enter WAIT.
REQ-027 In WAIT, the edge that samples div_done=1 SHALL capture the sign-corrected div_quotient and div_remainder into the rsp registers and enter RESP; rsp_valid rises in the following cycle.
REQ-028 Sign correction SHALL negate each result whose latched sign flag is 1; unsigned requests pass through unchanged.
REQ-029 The signed overflow case 32'h80000000 / 32'hFFFFFFFF SHALL return quotient 32'h80000000 and remainder 0.
REQ-030 A cycle counter SHALL start at 0 on entry to ISSUE; if it reaches TIMEOUT_CYCLES while still in ISSUE or WAIT, the block SHALL enter RESP with rsp_timeout=1, quotient 0 and remainder 0.
REQ-031 rsp_valid SHALL be 1 only in RESP; rsp_* outputs SHALL hold stable while rsp_valid=1 and rsp_ready=0.
REQ-032 At an edge where rsp_valid=1 and rsp_ready=1, the block SHALL return to IDLE; no new request is accepted at that edge.
REQ-033 div_dividend and div_divisor SHALL hold their last value outside the accept edge, so the divider never restarts spuriously.
REQ-034 An accepted request whose magnitudes equal the currently held div_* values SHALL still run ISSUE/WAIT; the divider's stable div_done then completes it after BLANK_CYCLES.
REQ-035 rsp_dbz and rsp_timeout SHALL be mutually exclusive and SHALL clear on return to IDLE.

Reset
REQ-036 While rst_n=0, the block SHALL be in IDLE with req_ready=1 and all of the following at 0: rsp_valid, rsp_dbz, rsp_timeout, rsp_quotient, rsp_remainder, div_dividend, div_divisor, and the cycle counter.
REQ-037 Reset asserted in any state SHALL abandon the operation immediately; no response is produced after reset release.
REQ-038 The first accept after reset release SHALL be possible on the first rising edge where rst_n=1.

Verification
REQ-039 Unsigned 100/7 with a model divider (34-cycle latency) -> rsp_quotient=14, rsp_remainder=2, rsp_dbz=0, rsp_timeout=0.
REQ-040 Signed -7/2 -> div_dividend=7, div_divisor=2; rsp_quotient=32'hFFFFFFFD, rsp_remainder=32'hFFFFFFFF.
REQ-041 Divisor 0 with dividend 32'h1234 -> rsp_valid one cycle after accept; quotient 32'hFFFFFFFF, remainder 32'h1234, rsp_dbz=1, div_* unchanged.
REQ-042 Signed 32'h80000000/32'hFFFFFFFF -> quotient 32'h80000000, remainder 0.
REQ-043 div_done held 0 -> rsp_timeout=1 after TIMEOUT_CYCLES; rsp_ready held 0 for 5 cycles -> outputs stable; rsp_ready=1 -> IDLE.
REQ-044 rst_n pulsed low during WAIT -> all outputs 0 immediately, req_ready=1, no rsp_valid afterwards; the next request completes correctly.
